// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: drives the instruction memory request, buffers one
// response across a stall, and steers the PC on branch/trap/mret redirects.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stop_IF,
    input  logic        set_invalid_IF,
    input  logic        took_branch,
    input  logic [31:0] branch_target,
    input  logic        any_excep,
    input  logic [31:0] trap_vector,
    input  logic        ret,
    input  logic [31:0] mepc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_instr,
    output logic        IF_invalid
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_DROP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] stale_q, stale_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic        out_inv_q, out_inv_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic        hold_vld_q, hold_vld_d;

    logic        redirect_s;
    logic [31:0] target_s;

    // Redirect arbitration: branch beats trap beats mret.
    always_comb begin
        redirect_s = took_branch | any_excep | ret;
        if (took_branch) begin
            target_s = branch_target;
        end else if (any_excep) begin
            target_s = trap_vector;
        end else if (ret) begin
            target_s = mepc;
        end else begin
            target_s = pc_q;
        end
    end

    // Memory request decode; DROP keeps presenting the abandoned address.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc_q;
        case (state_q)
            S_REQ: begin
                imem_req  = ~reset;
                imem_addr = pc_q;
            end
            S_HOLD: begin
                imem_req  = 1'b0;
                imem_addr = pc_q;
            end
            S_DROP: begin
                imem_req  = ~reset;
                imem_addr = stale_q;
            end
            default: begin
                imem_req  = 1'b0;
                imem_addr = pc_q;
            end
        endcase
    end

    // Next-state and register-update logic for the fetch FSM.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        stale_d      = stale_q;
        out_pc_d     = out_pc_q;
        out_instr_d  = out_instr_q;
        out_inv_d    = out_inv_q;
        hold_pc_d    = hold_pc_q;
        hold_instr_d = hold_instr_q;
        hold_vld_d   = hold_vld_q;

        case (state_q)
            S_REQ: begin
                if (redirect_s) begin
                    pc_d        = target_s;
                    out_pc_d    = 32'd0;
                    out_instr_d = NOP_INSTR;
                    out_inv_d   = 1'b1;
                    hold_vld_d  = 1'b0;
                    if (imem_ready) begin
                        state_d = S_REQ;
                    end else begin
                        state_d = S_DROP;
                        stale_d = pc_q;
                    end
                end else if (imem_ready) begin
                    pc_d = pc_q + 32'd4;
                    if (stop_IF) begin
                        hold_pc_d    = pc_q;
                        hold_instr_d = imem_rdata;
                        hold_vld_d   = 1'b1;
                        state_d      = S_HOLD;
                    end else begin
                        out_pc_d    = pc_q;
                        out_instr_d = imem_rdata;
                        out_inv_d   = 1'b0;
                    end
                end else if (!stop_IF) begin
                    out_pc_d    = 32'd0;
                    out_instr_d = NOP_INSTR;
                    out_inv_d   = 1'b1;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_HOLD: begin
                if (redirect_s) begin
                    pc_d        = target_s;
                    out_pc_d    = 32'd0;
                    out_instr_d = NOP_INSTR;
                    out_inv_d   = 1'b1;
                    hold_vld_d  = 1'b0;
                    state_d     = S_REQ;
                end else if (!stop_IF) begin
                    if (hold_vld_q) begin
                        out_pc_d    = hold_pc_q;
                        out_instr_d = hold_instr_q;
                        out_inv_d   = 1'b0;
                    end else begin
                        out_pc_d    = 32'd0;
                        out_instr_d = NOP_INSTR;
                        out_inv_d   = 1'b1;
                    end
                    hold_vld_d = 1'b0;
                    state_d    = S_REQ;
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_DROP: begin
                if (redirect_s) begin
                    pc_d = target_s;
                end else begin
                    pc_d = pc_q;
                end
                if (redirect_s || !stop_IF) begin
                    out_pc_d    = 32'd0;
                    out_instr_d = NOP_INSTR;
                    out_inv_d   = 1'b1;
                end else begin
                    out_inv_d = out_inv_q;
                end
                if (imem_ready) begin
                    state_d = S_REQ;
                end else begin
                    state_d = S_DROP;
                end
            end
            default: begin
                state_d     = S_REQ;
                out_pc_d    = 32'd0;
                out_instr_d = NOP_INSTR;
                out_inv_d   = 1'b1;
                hold_vld_d  = 1'b0;
            end
        endcase

        // A flush kills whatever is visible or parked, but never moves the PC.
        if (set_invalid_IF) begin
            out_pc_d    = 32'd0;
            out_instr_d = NOP_INSTR;
            out_inv_d   = 1'b1;
            hold_vld_d  = 1'b0;
        end else begin
            hold_vld_d = hold_vld_d;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            stale_q      <= RESET_PC;
            out_pc_q     <= 32'd0;
            out_instr_q  <= NOP_INSTR;
            out_inv_q    <= 1'b1;
            hold_pc_q    <= 32'd0;
            hold_instr_q <= NOP_INSTR;
            hold_vld_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            stale_q      <= stale_d;
            out_pc_q     <= out_pc_d;
            out_instr_q  <= out_instr_d;
            out_inv_q    <= out_inv_d;
            hold_pc_q    <= hold_pc_d;
            hold_instr_q <= hold_instr_d;
            hold_vld_q   <= hold_vld_d;
        end
    end

    assign IF_PC      = out_pc_q;
    assign IF_instr   = out_instr_q;
    assign IF_invalid = out_inv_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed vector table,
// hand-written corner sequences and a randomized run against a queue model.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        stop_IF, set_invalid_IF, took_branch, any_excep, ret;
    logic [31:0] branch_target, trap_vector, mepc;
    logic        imem_req, imem_ready;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] IF_PC, IF_instr;
    logic        IF_invalid;

    instruction_fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .clk            (clk),
        .reset          (reset),
        .stop_IF        (stop_IF),
        .set_invalid_IF (set_invalid_IF),
        .took_branch    (took_branch),
        .branch_target  (branch_target),
        .any_excep      (any_excep),
        .trap_vector    (trap_vector),
        .ret            (ret),
        .mepc           (mepc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .IF_PC          (IF_PC),
        .IF_instr       (IF_instr),
        .IF_invalid     (IF_invalid)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        inv;
    } rec_t;

    // Reference model: fetch PC, whether fetching is parked behind a stall,
    // addresses whose responses must be thrown away, and parked words.
    logic [31:0] m_pc;
    logic        m_parked;
    logic [31:0] m_drop[$];
    rec_t        m_buf[$];
    rec_t        m_out;

    logic        s_req;
    logic [31:0] s_addr;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    function automatic rec_t bubble();
        rec_t r;
        r.pc = 32'd0; r.instr = NOP_INSTR; r.inv = 1'b1;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = RESET_PC;
        m_parked = 1'b0;
        m_drop.delete();
        m_buf.delete();
        m_out = bubble();
    endtask

    // One clock: drive inputs, check request side, advance model, check IF side.
    task automatic cycle(input logic stp, input logic fl, input logic br, input logic [31:0] bt,
                         input logic ex, input logic [31:0] tv, input logic rt,
                         input logic [31:0] mp, input logic rdy);
        logic        exp_req, resp, redir;
        logic [31:0] exp_addr, tgt;
        rec_t        w;
        exp_req  = !m_parked;
        exp_addr = (m_drop.size() > 0) ? m_drop[0] : m_pc;
        stop_IF = stp; set_invalid_IF = fl; took_branch = br; branch_target = bt;
        any_excep = ex; trap_vector = tv; ret = rt; mepc = mp;
        imem_ready = rdy && exp_req;
        imem_rdata = imem_ready ? mem(exp_addr) : $urandom();
        #1;
        s_req = imem_req; s_addr = imem_addr;
        chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
        if (exp_req) chk("imem_addr", imem_addr, exp_addr);

        resp  = imem_ready;
        redir = br | ex | rt;
        tgt   = br ? bt : (ex ? tv : mp);
        if (redir) begin
            if (m_drop.size() > 0) begin
                if (resp) m_drop.delete();
            end else if (!m_parked && !resp) begin
                m_drop.push_back(m_pc);
            end
            m_out = bubble();
            m_buf.delete();
            m_parked = 1'b0;
            m_pc = tgt;
        end else if (m_drop.size() > 0) begin
            if (resp) m_drop.delete();
            if (!stp) m_out = bubble();
        end else if (m_parked) begin
            if (!stp) begin
                m_out = (m_buf.size() > 0) ? m_buf[0] : bubble();
                m_buf.delete();
                m_parked = 1'b0;
            end
        end else begin
            if (resp) begin
                w.pc = m_pc; w.instr = mem(m_pc); w.inv = 1'b0;
                m_pc = m_pc + 32'd4;
                if (stp) begin
                    m_buf.push_back(w);
                    m_parked = 1'b1;
                end else begin
                    m_out = w;
                end
            end else if (!stp) begin
                m_out = bubble();
            end
        end
        if (fl) begin
            m_out = bubble();
            m_buf.delete();
        end

        @(posedge clk);
        #1;
        chk("IF_PC", IF_PC, m_out.pc);
        chk("IF_instr", IF_instr, m_out.instr);
        chk("IF_invalid", {31'd0, IF_invalid}, {31'd0, m_out.inv});
    endtask

    typedef struct {
        logic        stp, fl, br;
        logic [31:0] bt;
        logic        ex;
        logic [31:0] tv;
        logic        rdy;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_inv;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t tbl[12];

    initial begin
        // stp fl br bt ex tv rdy | req addr inv pc
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1, 32'h0,   1'b0, 32'h0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1, 32'h4,   1'b0, 32'h4};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1, 32'h8,   1'b0, 32'h4};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 32'h4};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 32'h4};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 32'h8};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0,   1'b0, 1'b1, 32'hC,   1'b1, 32'h0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b1, 32'hC,   1'b1, 32'h0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1, 32'hC,   1'b1, 32'h0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 1'b0, 32'h100};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 32'h300, 1'b1, 1'b1, 32'h104, 1'b1, 32'h0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1, 32'h200, 1'b0, 32'h200};

        reset = 1'b1;
        stop_IF = 1'b0; set_invalid_IF = 1'b0; took_branch = 1'b0; any_excep = 1'b0; ret = 1'b0;
        branch_target = 32'd0; trap_vector = 32'd0; mepc = 32'd0;
        imem_ready = 1'b0; imem_rdata = 32'd0;
        #3;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_pc", IF_PC, 32'd0);
        chk("rst_instr", IF_instr, NOP_INSTR);
        chk("rst_inv", {31'd0, IF_invalid}, 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();

        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].stp, tbl[i].fl, tbl[i].br, tbl[i].bt, tbl[i].ex, tbl[i].tv,
                  1'b0, 32'h0, tbl[i].rdy);
            chk($sformatf("tbl%0d_req", i), {31'd0, s_req}, {31'd0, tbl[i].exp_req});
            if (tbl[i].exp_req) chk($sformatf("tbl%0d_addr", i), s_addr, tbl[i].exp_addr);
            chk($sformatf("tbl%0d_inv", i), {31'd0, IF_invalid}, {31'd0, tbl[i].exp_inv});
            chk($sformatf("tbl%0d_pc", i), IF_PC, tbl[i].exp_pc);
            chk($sformatf("tbl%0d_instr", i), IF_instr, tbl[i].exp_inv ? NOP_INSTR : mem(tbl[i].exp_pc));
        end

        // PC wrap at the top of the address space.
        cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("wrap_addr_top", s_addr, 32'hFFFF_FFFC);
        chk("wrap_pc_top", IF_PC, 32'hFFFF_FFFC);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("wrap_addr_zero", s_addr, 32'h0);

        // Trap beats mret.
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h300, 1'b1, 32'h400, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("trap_over_ret", s_addr, 32'h300);

        // Reset asserted while a stalled response is parked.
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("hold_req_low", {31'd0, s_req}, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
        chk("mid_rst_pc", IF_PC, 32'd0);
        chk("mid_rst_instr", IF_instr, NOP_INSTR);
        chk("mid_rst_inv", {31'd0, IF_invalid}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        stop_IF = 1'b0;
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("post_rst_req", {31'd0, s_req}, 32'd1);
        chk("post_rst_addr", s_addr, RESET_PC);

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            logic stp, fl, br, ex, rt, rdy;
            stp = ($urandom_range(0, 3) == 0);
            fl  = ($urandom_range(0, 19) == 0);
            br  = ($urandom_range(0, 19) == 0);
            ex  = ($urandom_range(0, 29) == 0);
            rt  = ($urandom_range(0, 29) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            cycle(stp, fl, br, $urandom() & 32'hFFFF_FFFC, ex, $urandom() & 32'hFFFF_FFFC,
                  rt, $urandom() & 32'hFFFF_FFFC, rdy);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
